serial_add_ctrl: RTL and testbench

//   Bit-serial add/subtract engine built around one 1-bit full adder (adder1).

---
 rtl/serial_add_ctrl_pkg.sv | 13 +
 rtl/serial_add_ctrl_adder1.sv | 13 +
 rtl/serial_add_ctrl.sv | 93 +++++++++
 tb/tb_serial_add_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types for the bit-serial add/subtract engine.
// State encodings are fixed so that other blocks can decode them.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    SA_IDLE = 2'd0,
    SA_RUN  = 2'd1,
    SA_DONE = 2'd2
  } sa_state_t;

  localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_ctrl_adder1.sv
// Single-bit full adder: the only arithmetic in the serial engine.
module adder1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract engine: feeds WIDTH operand bits LSB-first through
// one full adder, with a start/busy/done handshake.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sa_state_t        state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [CW-1:0]    count;
  logic             carry;
  logic             fa_sum;
  logic             fa_cout;

  adder1 u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Subtraction is A + ~B + 1: B is inverted on accept and the +1 enters as
  // the initial carry. During the last bit, carry holds the carry into the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= SA_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      count  <= '0;
      carry  <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        SA_IDLE: begin
          if (start) begin
            a_sr   <= a_in;
            b_sr   <= sub ? ~b_in : b_in;
            carry  <= sub;
            count  <= '0;
            result <= '0;
            busy   <= 1'b1;
            state  <= SA_RUN;
          end
        end
        SA_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          result <= {fa_sum, result[WIDTH-1:1]};
          carry  <= fa_cout;
          count  <= count + CW'(1);
          if (count == LAST) begin
            cout  <= fa_cout;
            ovf   <= carry ^ fa_cout;
            done  <= 1'b1;
            state <= SA_DONE;
          end
        end
        SA_DONE: begin
          busy  <= 1'b0;
          state <= SA_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= SA_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed vectors plus a random
// sweep, compared every cycle against a cycle-count/arithmetic model.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int nChecks = 0;
  int nErrors = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: mk counts cycles since accept (0 = idle); results come from plain
  // modular arithmetic computed when the operands are taken.
  int           mk = 0;
  logic [W-1:0] pendRes, heldRes;
  logic         pendCout, heldCout, pendOvf, heldOvf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mk = 0;
      heldRes = '0;
      heldCout = 1'b0;
      heldOvf = 1'b0;
    end else if (mk == 0) begin
      if (start) begin
        mk = 1;
        if (sub) begin
          pendRes  = a_in - b_in;
          pendCout = (a_in >= b_in);
          pendOvf  = (a_in[W-1] != b_in[W-1]) && (pendRes[W-1] != a_in[W-1]);
        end else begin
          {pendCout, pendRes} = {1'b0, a_in} + {1'b0, b_in};
          pendOvf  = (a_in[W-1] == b_in[W-1]) && (pendRes[W-1] != a_in[W-1]);
        end
      end
    end else begin
      mk++;
      if (mk == W + 1) begin
        heldRes  = pendRes;
        heldCout = pendCout;
        heldOvf  = pendOvf;
      end else if (mk == W + 2) begin
        mk = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("busy", {31'd0, busy}, {31'd0, (mk >= 1 && mk <= W + 1)});
      checkOutput("done", {31'd0, done}, {31'd0, (mk == W + 1)});
      if (mk == 0 || mk == W + 1) begin
        checkOutput("model_result", {24'd0, result}, {24'd0, heldRes});
        checkOutput("model_cout", {31'd0, cout}, {31'd0, heldCout});
        checkOutput("model_ovf", {31'd0, ovf}, {31'd0, heldOvf});
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic s);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    sub   = s;
    start = 1'b1;
  endtask

  // Waits for done, dropping start and scrambling operands after accept.
  task automatic waitDone(output int cycles);
    cycles = 0;
    while (1) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        start = 1'b0;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        sub   = $urandom_range(0, 1) == 1;
      end
      if (done) break;
      if (cycles > 30) begin
        checkOutput("done_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic runOp(input string name, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] eRes, input logic eCout,
                       input logic eOvf);
    int cyc;
    applyStimulus(a, b, s);
    waitDone(cyc);
    checkOutput({name, "_latency"}, cyc, W + 1);
    checkOutput({name, "_result"}, {24'd0, result}, {24'd0, eRes});
    checkOutput({name, "_cout"}, {31'd0, cout}, {31'd0, eCout});
    checkOutput({name, "_ovf"}, {31'd0, ovf}, {31'd0, eOvf});
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_result", {24'd0, result}, 32'd0);

    runOp("add_35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    runOp("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    runOp("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    runOp("sub_10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    runOp("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Starts during RUN and DONE are ignored; the next IDLE start is taken.
    applyStimulus(8'h22, 8'h11, 1'b0);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (cyc == 3) begin start = 1'b1; a_in = 8'h77; b_in = 8'h77; end
      if (cyc == 4) start = 1'b0;
      if (done || cyc > 30) break;
    end
    checkOutput("ignore_run_result", {24'd0, result}, 32'h33);
    a_in = 8'h05; b_in = 8'h03; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    checkOutput("ignore_done_busy", {31'd0, busy}, 32'd0);
    checkOutput("ignore_done_result", {24'd0, result}, 32'h33);
    @(negedge clk);
    start = 1'b0;
    checkOutput("idle_accept_busy", {31'd0, busy}, 32'd1);
    waitDone(cyc);
    checkOutput("idle_accept_result", {24'd0, result}, 32'h02);
    checkOutput("idle_accept_cout", {31'd0, cout}, 32'd1);

    // Asynchronous reset in the middle of RUN.
    applyStimulus(8'hC3, 8'h5A, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_result", {24'd0, result}, 32'd0);
    checkOutput("rst_cout", {31'd0, cout}, 32'd0);
    checkOutput("rst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    runOp("post_rst_add", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    for (int i = 0; i < 500; i++) begin
      applyStimulus(W'($urandom), W'($urandom), $urandom_range(0, 1) == 1);
      waitDone(cyc);
      checkOutput("rand_latency", cyc, W + 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
    $finish;
  end

endmodule
